trit_pack_sequencer: RTL
========================

Name: trit_pack_sequencer

Overview:
- Controller for the Encaps ternary-packing datapath: 2-trit mod3 shifter → 5-trit-to-byte packers → 16-bit-per-shift hash input buffer → hash absorb.
- Pulls random words from the RNG through a valid/ready handshake and issues the shifter/packer/buffer enables.
- Hands each filled buffer block to the hash unit, including a final partial block flagged last.

Parameters:
- SHIFTS_PER_GROUP, 5, 2-trit shifts per group (10 trits → 2 bytes).
- WORDS_PER_BLOCK, 68, 16-bit buffer shifts per hash block (1088 bits).
- TOTAL_GROUPS, 70, groups per message (700 trits).

Ports:
- clk  in  1  clock.
- ovr_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a message.
- rnd_valid  in  1  RNG word available.
- rnd_ready  out  1  controller accepts RNG word.
- sh1_en  out  1  trit shifter and packer shift enable.
- grp_cnt  out  3  current shift index within group, 0..SHIFTS_PER_GROUP-1.
- pack_clr  out  1  clears packer accumulators.
- sh2_en  out  1  hash buffer shift enable.
- blk_clr  out  1  clears hash buffer.
- blk_valid  out  1  hash block ready.
- blk_ready  in  1  hash unit accepts block.
- blk_last  out  1  block is final.
- blk_words  out  7  valid 16-bit words in offered block.
- busy  out  1  message in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0. State IDLE. All counters 0. Reset mid-operation aborts immediately with no completion pulse.
- States: IDLE, FILL, PACK, HASH, DONE.
- IDLE
  - start=1 → FILL next cycle.
  - blk_clr and pack_clr pulse for 1 cycle in that transition cycle.
  - Counters cleared.
- FILL
  - busy=1. rnd_ready=1.
  - sh1_en = rnd_valid & rnd_ready, combinational, same cycle.
  - Each accept increments grp_cnt.
  - Accept with grp_cnt==SHIFTS_PER_GROUP-1 → grp_cnt wraps to 0 and the state goes to PACK.
  - rnd_valid=0 holds all state.
- PACK
  - Exactly 1 cycle. rnd_ready=0. sh2_en=1. pack_clr=1.
  - Increments word_cnt and total group count.
  - If word_cnt+1==WORDS_PER_BLOCK or groups+1==TOTAL_GROUPS → HASH. Else → FILL.
- HASH
  - blk_valid=1 and held stable until blk_ready.
  - blk_words = word_cnt.
  - blk_last = 1 iff all TOTAL_GROUPS have been packed.
  - blk_ready=1 while blk_valid=1 completes the transfer that cycle.
    - If last → DONE.
    - Else → FILL with word_cnt=0 and a blk_clr pulse in the same cycle.
- DONE: done=1 for 1 cycle, busy=0, then IDLE.
- start outside IDLE is ignored.
- blk_ready outside HASH is ignored.
- Defaults: 70 groups give blocks of 68 words (last=0) and 2 words (last=1).
- Counter widths: clog2 of the respective parameter. blk_words is sized to hold WORDS_PER_BLOCK.
- Each FILL→PACK adds exactly one idle RNG cycle. No shifting occurs in PACK or HASH.

Optional Feature:
- Macro: TRIT_PACK_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt[15:0], a saturating count of FILL cycles with rnd_valid=0 plus HASH cycles with blk_ready=0.
  - Cleared on the start accept and on reset.
  - Holds its value after DONE.
- Undefined: port and logic absent. All other behaviour identical.

Decomposition:
- Package trit_pack_pkg:
  - state enum (IDLE, FILL, PACK, HASH, DONE).
  - Default parameter constants.
  - Bits per shift (4) and bits per buffer word (16).
- One sub-module trit_pack_counters:
  - group, word and total counters with terminal-count flags.
  - The FSM stays in trit_pack_sequencer.

Test Plan:
1. Defaults, rnd_valid tied 1, blk_ready tied 1:
   - 350 sh1_en and 70 sh2_en pulses.
   - blk_valid with blk_words=68/last=0, then blk_words=2/last=1.
   - done 1 cycle after the second handshake.
   - busy high from the cycle after start to DONE.
2. rnd_valid toggling 1,0,1,0:
   - sh1_en only on valid cycles.
   - grp_cnt holds during gaps.
   - sh2_en count still 70, total 350 accepts.
3. blk_ready delayed 10 cycles:
   - blk_valid/blk_words/blk_last stable 10 cycles.
   - rnd_ready=0 and sh1_en=0 throughout.
   - stall_cnt increments by 10 when TRIT_PACK_STALL_CNT_EN is defined.
4. ovr_rst at the 100th accept:
   - All outputs 0 asynchronously. No done.
   - Subsequent start runs a full correct message.
5. start pulsed in FILL and HASH: ignored, counts unchanged.
6. Parameters SHIFTS_PER_GROUP=5, WORDS_PER_BLOCK=2, TOTAL_GROUPS=4:
   - Two blocks of 2 words, last on the second.
   - blk_clr pulses at the start accept and after the first block accept.

Source files
------------

// File: rtl/trit_pack_pkg.sv
// Shared types and default constants for the Encaps trit-packing sequencer.
package trit_pack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_PACK = 3'd2,
    ST_HASH = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int SHIFTS_PER_GROUP_DEF = 5;
  localparam int WORDS_PER_BLOCK_DEF  = 68;
  localparam int TOTAL_GROUPS_DEF     = 70;
  localparam int BITS_PER_SHIFT       = 4;
  localparam int BITS_PER_WORD        = 16;
  localparam int GRP_CNT_W            = 3;
  localparam int BLK_WORDS_W          = 7;
  localparam int STALL_W              = 16;

  // Bits needed to hold 0..max_val (never narrower than one bit).
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/trit_pack_sequencer_if.sv
// Handshake/enable bundle between the sequencer and the packing datapath.
// stall_cnt exists only when TRIT_PACK_STALL_CNT_EN is defined.
interface trit_pack_sequencer_if;
  import trit_pack_pkg::*;

  logic                   start;
  logic                   rnd_valid;
  logic                   rnd_ready;
  logic                   sh1_en;
  logic [GRP_CNT_W-1:0]   grp_cnt;
  logic                   pack_clr;
  logic                   sh2_en;
  logic                   blk_clr;
  logic                   blk_valid;
  logic                   blk_ready;
  logic                   blk_last;
  logic [BLK_WORDS_W-1:0] blk_words;
  logic                   busy;
  logic                   done;
`ifdef TRIT_PACK_STALL_CNT_EN
  logic [STALL_W-1:0]     stall_cnt;
`endif

  modport master (
    input  start, rnd_valid, blk_ready,
    output rnd_ready, sh1_en, grp_cnt, pack_clr, sh2_en, blk_clr,
           blk_valid, blk_last, blk_words, busy, done
`ifdef TRIT_PACK_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output start, rnd_valid, blk_ready,
    input  rnd_ready, sh1_en, grp_cnt, pack_clr, sh2_en, blk_clr,
           blk_valid, blk_last, blk_words, busy, done
`ifdef TRIT_PACK_STALL_CNT_EN
    , input stall_cnt
`endif
  );

endinterface

// File: rtl/trit_pack_counters.sv
// Group-shift, block-word and message-group counters with terminal flags.
module trit_pack_counters
  import trit_pack_pkg::*;
#(
  parameter int SHIFTS_PER_GROUP = SHIFTS_PER_GROUP_DEF,
  parameter int WORDS_PER_BLOCK  = WORDS_PER_BLOCK_DEF,
  parameter int TOTAL_GROUPS     = TOTAL_GROUPS_DEF,
  parameter int GW = cnt_width(SHIFTS_PER_GROUP - 1),
  parameter int WW = cnt_width(WORDS_PER_BLOCK),
  parameter int TW = cnt_width(TOTAL_GROUPS)
) (
  input  logic          clk,
  input  logic          ovr_rst,
  input  logic          clr_all,
  input  logic          grp_inc,
  input  logic          pack_inc,
  input  logic          word_clr,
  output logic [GW-1:0] grp_cnt,
  output logic [WW-1:0] word_cnt,
  output logic          grp_tc,
  output logic          word_tc,
  output logic          tot_tc,
  output logic          all_packed
);

  localparam logic [GW-1:0] GRP_ONE  = GW'(1);
  localparam logic [WW-1:0] WORD_ONE = WW'(1);
  localparam logic [TW-1:0] TOT_ONE  = TW'(1);

  logic [GW-1:0] grp_cnt_r;
  logic [WW-1:0] word_cnt_r;
  logic [TW-1:0] tot_cnt_r;

  // Counter registers; the group index wraps on its terminal shift.
  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      grp_cnt_r  <= {GW{1'b0}};
      word_cnt_r <= {WW{1'b0}};
      tot_cnt_r  <= {TW{1'b0}};
    end else if (clr_all) begin
      grp_cnt_r  <= {GW{1'b0}};
      word_cnt_r <= {WW{1'b0}};
      tot_cnt_r  <= {TW{1'b0}};
    end else begin
      if (grp_inc) begin
        grp_cnt_r <= grp_tc ? {GW{1'b0}} : grp_cnt_r + GRP_ONE;
      end
      if (pack_inc) begin
        word_cnt_r <= word_cnt_r + WORD_ONE;
        tot_cnt_r  <= tot_cnt_r + TOT_ONE;
      end else if (word_clr) begin
        word_cnt_r <= {WW{1'b0}};
      end
    end
  end

  assign grp_cnt    = grp_cnt_r;
  assign word_cnt   = word_cnt_r;
  assign grp_tc     = (grp_cnt_r == GW'(SHIFTS_PER_GROUP - 1));
  assign word_tc    = (word_cnt_r == WW'(WORDS_PER_BLOCK - 1));
  assign tot_tc     = (tot_cnt_r == TW'(TOTAL_GROUPS - 1));
  assign all_packed = (tot_cnt_r == TW'(TOTAL_GROUPS));

endmodule

// File: rtl/trit_pack_sequencer.sv
// Sequencer for the trit shifter -> packer -> hash buffer -> absorb chain.
// Optional stall_cnt output enabled by defining TRIT_PACK_STALL_CNT_EN.
module trit_pack_sequencer
  import trit_pack_pkg::*;
#(
  parameter int SHIFTS_PER_GROUP = SHIFTS_PER_GROUP_DEF,
  parameter int WORDS_PER_BLOCK  = WORDS_PER_BLOCK_DEF,
  parameter int TOTAL_GROUPS     = TOTAL_GROUPS_DEF
) (
  input  logic                  clk,
  input  logic                  ovr_rst,
  trit_pack_sequencer_if.master bus
);

  localparam int GW = cnt_width(SHIFTS_PER_GROUP - 1);
  localparam int WW = cnt_width(WORDS_PER_BLOCK);
  localparam int TW = cnt_width(TOTAL_GROUPS);

  state_e                 state_r, state_s;
  logic                   clr_all_s, grp_inc_s, pack_inc_s, word_clr_s;
  logic                   grp_tc_s, word_tc_s, tot_tc_s, all_packed_s;
  logic [GW-1:0]          grp_cnt_s;
  logic [WW-1:0]          word_cnt_s;
  logic                   rnd_ready_s, sh1_en_s, pack_clr_s, sh2_en_s;
  logic                   blk_clr_s, blk_valid_s, blk_last_s, busy_s, done_s;
  logic [BLK_WORDS_W-1:0] blk_words_s;

  trit_pack_counters #(
    .SHIFTS_PER_GROUP (SHIFTS_PER_GROUP),
    .WORDS_PER_BLOCK  (WORDS_PER_BLOCK),
    .TOTAL_GROUPS     (TOTAL_GROUPS),
    .GW               (GW),
    .WW               (WW),
    .TW               (TW)
  ) u_counters (
    .clk        (clk),
    .ovr_rst    (ovr_rst),
    .clr_all    (clr_all_s),
    .grp_inc    (grp_inc_s),
    .pack_inc   (pack_inc_s),
    .word_clr   (word_clr_s),
    .grp_cnt    (grp_cnt_s),
    .word_cnt   (word_cnt_s),
    .grp_tc     (grp_tc_s),
    .word_tc    (word_tc_s),
    .tot_tc     (tot_tc_s),
    .all_packed (all_packed_s)
  );

  // State register.
  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and datapath enables; enables are decoded from state plus handshakes.
  always_comb begin
    state_s     = state_r;
    rnd_ready_s = 1'b0;
    sh1_en_s    = 1'b0;
    pack_clr_s  = 1'b0;
    sh2_en_s    = 1'b0;
    blk_clr_s   = 1'b0;
    blk_valid_s = 1'b0;
    blk_last_s  = 1'b0;
    blk_words_s = {BLK_WORDS_W{1'b0}};
    busy_s      = 1'b0;
    done_s      = 1'b0;
    clr_all_s   = 1'b0;
    grp_inc_s   = 1'b0;
    pack_inc_s  = 1'b0;
    word_clr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s    = ST_FILL;
          blk_clr_s  = 1'b1;
          pack_clr_s = 1'b1;
          clr_all_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        busy_s      = 1'b1;
        rnd_ready_s = 1'b1;
        if (bus.rnd_valid) begin
          sh1_en_s  = 1'b1;
          grp_inc_s = 1'b1;
          state_s   = grp_tc_s ? ST_PACK : ST_FILL;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_PACK: begin
        busy_s     = 1'b1;
        sh2_en_s   = 1'b1;
        pack_clr_s = 1'b1;
        pack_inc_s = 1'b1;
        if (word_tc_s || tot_tc_s) begin
          state_s = ST_HASH;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_HASH: begin
        busy_s      = 1'b1;
        blk_valid_s = 1'b1;
        blk_last_s  = all_packed_s;
        blk_words_s = BLK_WORDS_W'(word_cnt_s);
        if (bus.blk_ready) begin
          if (all_packed_s) begin
            state_s = ST_DONE;
          end else begin
            state_s    = ST_FILL;
            word_clr_s = 1'b1;
            blk_clr_s  = 1'b1;
          end
        end else begin
          state_s = ST_HASH;
        end
      end
      ST_DONE: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign bus.rnd_ready = rnd_ready_s;
  assign bus.sh1_en    = sh1_en_s;
  assign bus.grp_cnt   = GRP_CNT_W'(grp_cnt_s);
  assign bus.pack_clr  = pack_clr_s;
  assign bus.sh2_en    = sh2_en_s;
  assign bus.blk_clr   = blk_clr_s;
  assign bus.blk_valid = blk_valid_s;
  assign bus.blk_last  = blk_last_s;
  assign bus.blk_words = blk_words_s;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;

`ifdef TRIT_PACK_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt_r;
  logic               stall_evt_s;

  assign stall_evt_s = ((state_r == ST_FILL) && !bus.rnd_valid) ||
                       ((state_r == ST_HASH) && !bus.blk_ready);

  // Saturating stall counter, cleared when a new message is accepted.
  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      stall_cnt_r <= {STALL_W{1'b0}};
    end else if (clr_all_s) begin
      stall_cnt_r <= {STALL_W{1'b0}};
    end else if (stall_evt_s && (stall_cnt_r != {STALL_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
`endif

endmodule
